// File: rtl/remora_pkg.sv
// Shared definitions for the command-frame controller: FSM state encoding,
// frame headers, field positions inside the 240-bit SPI frame and the
// little-endian byte-swap helpers used to decode multi-byte fields.
package remora_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_RUN     = 2'd1,
        S_TIMEOUT = 2'd2,
        S_ESTOP   = 2'd3
    } state_t;

    localparam logic [31:0] HDR_DATA = 32'h64617461;  // "data"
    localparam logic [31:0] HDR_ESTP = 32'h65737470;  // "estp"

    // MSB position of each field; the byte at the highest bits is the LSB.
    localparam int HDR_MSB      = 239;
    localparam int JOINT0_MSB   = 207;
    localparam int JOINT_STRIDE = 32;
    localparam int SP0_MSB      = 47;
    localparam int SP1_MSB      = 31;
    localparam int EN_MSB       = 15;
    localparam int DOUT_MSB     = 7;
    localparam int MAX_JOINTS   = 5;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/frame_cmd_ctrl_if.sv
// Frame hand-off from the SPI slave: the captured frame and its
// one-cycle completion strobe. rx_data is held stable while pkg_ok is high.
interface frame_cmd_ctrl_if #(
    parameter int BUFFER_SIZE = 240
);
    logic [BUFFER_SIZE-1:0] rx_data;
    logic                   pkg_ok;

    modport master (
        output rx_data,
        output pkg_ok
    );

    modport slave (
        input rx_data,
        input pkg_ok
    );
endinterface

// File: rtl/frame_watchdog.sv
// Frame watchdog: counts cycles spent in RUN since the last valid frame and
// flags expiry on the last cycle of the period. The counter sits at zero
// whenever run is low, and restarts from zero on clr or on expiry.
// Compiled only when FRAME_WATCHDOG_EN is defined.
`ifdef FRAME_WATCHDOG_EN
module frame_watchdog #(
    parameter int TIMEOUT_CYCLES = 4800000
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Up-count while running; any reload, idle or expiry parks it at zero.
    always_ff @(posedge sysclk) begin
        if (rst || clr || !run || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule
`endif

// File: rtl/frame_cmd_ctrl.sv
// Command-frame controller between the SPI slave and the stepgen/PWM/DOUT
// datapath. Validates each frame header, latches joint commands, enables,
// PWM set-points and digital outputs atomically, and forces everything to
// zero on watchdog timeout or E-stop.
// Build option: FRAME_WATCHDOG_EN adds the frame watchdog and TIMEOUT state;
// without it RUN persists until E-stop or reset.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   WAIT    | armed, outputs zero, waiting for the first valid frame
//   RUN     | outputs follow the latest valid frame
//   TIMEOUT | no valid frame within the watchdog period, outputs zero
//   ESTOP   | E-stop latched, outputs zero until a safe re-arm frame
module frame_cmd_ctrl
    import remora_pkg::*;
#(
    parameter int BUFFER_SIZE    = 240,
    parameter int JOINTS         = 5,
    parameter int TIMEOUT_CYCLES = 4800000
) (
    input  logic                   sysclk,
    input  logic                   rst,
    frame_cmd_ctrl_if.slave        bus,
    input  logic                   estop_in,
    output logic [32*JOINTS-1:0]   jointFreqCmd,
    output logic [JOINTS-1:0]      jointEnable,
    output logic [31:0]            setPoint,
    output logic [7:0]             dout,
    output logic [31:0]            header_tx,
    output logic [1:0]             state,
    output logic                   error,
    output logic [15:0]            bad_hdr_cnt
);

    // The frame layout is fixed; refuse parameter sets it cannot describe.
    if (BUFFER_SIZE != 240 || JOINTS < 1 || JOINTS > MAX_JOINTS || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("frame_cmd_ctrl: unsupported parameter set");
    end

    logic [BUFFER_SIZE-1:0] frame;
    logic [31:0]            hdr_dec;
    logic [32*JOINTS-1:0]   cmd_dec;
    logic [JOINTS-1:0]      en_dec;
    logic [7:0]             en_byte;
    logic [31:0]            sp_dec;
    logic [7:0]             dout_dec;
    logic                   frame_valid;
    logic                   frame_bad;
    logic                   estop_meta;
    logic                   estop_s;
    logic                   wd_expired;
    state_t                 state_q;

    assign frame    = bus.rx_data;
    assign hdr_dec  = bswap32(frame[HDR_MSB -: 32]);
    assign en_byte  = frame[EN_MSB -: 8];
    assign sp_dec   = {bswap16(frame[SP1_MSB -: 16]), bswap16(frame[SP0_MSB -: 16])};
    assign dout_dec = frame[DOUT_MSB -: 8];

    for (genvar j = 0; j < JOINTS; j++) begin : g_joint
        assign cmd_dec[32*j +: 32] = bswap32(frame[JOINT0_MSB - JOINT_STRIDE*j -: 32]);
        assign en_dec[j]           = en_byte[7-j];
    end

    assign frame_valid = bus.pkg_ok && (hdr_dec == HDR_DATA);
    assign frame_bad   = bus.pkg_ok && (hdr_dec != HDR_DATA);
    assign state       = state_q;

    // Two-flop synchronizer for the asynchronous E-stop pin.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            estop_meta <= 1'b0;
            estop_s    <= 1'b0;
        end else begin
            estop_meta <= estop_in;
            estop_s    <= estop_meta;
        end
    end

    // Saturating count of frames rejected for a bad header, in any state.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            bad_hdr_cnt <= '0;
        end else if (frame_bad && bad_hdr_cnt != 16'hFFFF) begin
            bad_hdr_cnt <= bad_hdr_cnt + 16'd1;
        end
    end

`ifdef FRAME_WATCHDOG_EN
    frame_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .sysclk  (sysclk),
        .rst     (rst),
        .clr     (frame_valid),
        .run     (state_q == S_RUN && !estop_s),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // Sequencer with registered outputs: E-stop first, then valid frames,
    // then watchdog expiry. Re-arm from ESTOP needs a frame with no enables.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            jointFreqCmd <= '0;
            jointEnable  <= '0;
            setPoint     <= '0;
            dout         <= '0;
            error        <= 1'b0;
            header_tx    <= HDR_DATA;
        end else if (estop_s) begin
            state_q      <= S_ESTOP;
            jointFreqCmd <= '0;
            jointEnable  <= '0;
            setPoint     <= '0;
            dout         <= '0;
            error        <= 1'b1;
            header_tx    <= HDR_ESTP;
        end else begin
            case (state_q)
                S_ESTOP: begin
                    if (frame_valid && en_byte == 8'h00) begin
                        state_q   <= S_WAIT;
                        error     <= 1'b0;
                        header_tx <= HDR_DATA;
                    end
                end
                default: begin
                    if (frame_valid) begin
                        state_q      <= S_RUN;
                        jointFreqCmd <= cmd_dec;
                        jointEnable  <= en_dec;
                        setPoint     <= sp_dec;
                        dout         <= dout_dec;
                        error        <= 1'b0;
                        header_tx    <= HDR_DATA;
                    end else if (state_q == S_RUN && wd_expired) begin
                        state_q      <= S_TIMEOUT;
                        jointFreqCmd <= '0;
                        jointEnable  <= '0;
                        setPoint     <= '0;
                        dout         <= '0;
                        error        <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_cmd_ctrl.sv
// Bench for frame_cmd_ctrl. Frames are built from field records and encoded
// byte by byte; a cycle model driven by those records predicts every output.
module tb_frame_cmd_ctrl;

    localparam int          TC   = 100;
    localparam logic [31:0] DATA = 32'h64617461;
    localparam logic [31:0] ESTP = 32'h65737470;

    typedef struct packed {
        logic [31:0]       hdr;
        logic [4:0][31:0]  cmd;
        logic [7:0]        en;
        logic [15:0]       sp0;
        logic [15:0]       sp1;
        logic [7:0]        dout;
    } frame_t;

    logic         sysclk = 1'b0;
    logic         rst;
    logic         estop_in;
    logic [159:0] jfc;
    logic [4:0]   jen;
    logic [31:0]  sp;
    logic [7:0]   dout;
    logic [31:0]  htx;
    logic [1:0]   st;
    logic         err;
    logic [15:0]  bad;

    int n_checks = 0;
    int n_err    = 0;

    frame_t cur_f;

    always #5 sysclk = ~sysclk;

    frame_cmd_ctrl_if #(.BUFFER_SIZE(240)) fbus();

    frame_cmd_ctrl #(
        .BUFFER_SIZE    (240),
        .JOINTS         (5),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .bus          (fbus),
        .estop_in     (estop_in),
        .jointFreqCmd (jfc),
        .jointEnable  (jen),
        .setPoint     (sp),
        .dout         (dout),
        .header_tx    (htx),
        .state        (st),
        .error        (err),
        .bad_hdr_cnt  (bad)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte k of the frame sits at bits [239-8k -: 8]; fields are little-endian.
    function automatic logic [239:0] enc(input frame_t f);
        logic [7:0]   b [30];
        logic [239:0] r;
        for (int i = 0; i < 4; i++) b[i] = f.hdr[8*i +: 8];
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 4; i++) b[4+4*j+i] = f.cmd[j][8*i +: 8];
        b[24] = f.sp0[7:0];
        b[25] = f.sp0[15:8];
        b[26] = f.sp1[7:0];
        b[27] = f.sp1[15:8];
        b[28] = f.en;
        b[29] = f.dout;
        r = '0;
        for (int k = 0; k < 30; k++) r[239-8*k -: 8] = b[k];
        return r;
    endfunction

    function automatic frame_t mk(input logic [31:0] h, input logic [31:0] c0, input logic [31:0] c1,
                                  input logic [31:0] c2, input logic [31:0] c3, input logic [31:0] c4,
                                  input logic [7:0] en, input logic [15:0] s0, input logic [15:0] s1,
                                  input logic [7:0] d);
        frame_t f;
        f.hdr = h;
        f.cmd[0] = c0; f.cmd[1] = c1; f.cmd[2] = c2; f.cmd[3] = c3; f.cmd[4] = c4;
        f.en = en; f.sp0 = s0; f.sp1 = s1; f.dout = d;
        return f;
    endfunction

    // All drives happen 1 time unit after a rising edge.
    task automatic align();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) align();
    endtask

    task automatic send(input frame_t f);
        cur_f         = f;
        fbus.rx_data  = enc(f);
        fbus.pkg_ok   = 1'b1;
        align();
        fbus.pkg_ok   = 1'b0;
    endtask

    // Model: state after the last edge, the last latched frame, an E-stop
    // delay line and the number of RUN cycles since the last reload.
    int     m_state = 0;
    frame_t m_lat   = '0;
    logic   m_d1    = 1'b0;
    logic   m_d2    = 1'b0;
    int     m_idle  = 0;
    int     m_bad   = 0;
    bit     m_live  = 1'b0;

    always @(negedge sysclk) begin
        logic       now_s;
        logic       valid;
        logic [4:0] e;
        if (m_live) begin
            e = '0;
            for (int j = 0; j < 5; j++) e[j] = m_lat.en[7-j];
            chk("state", st, m_state);
            chk("error", err, (m_state >= 2));
            chk("header_tx", htx, (m_state == 3) ? ESTP : DATA);
            chk("jointFreqCmd", jfc, (m_state == 1) ? m_lat.cmd : '0);
            chk("jointEnable", jen, (m_state == 1) ? e : 5'd0);
            chk("setPoint", sp, (m_state == 1) ? {m_lat.sp1, m_lat.sp0} : 32'd0);
            chk("dout", dout, (m_state == 1) ? m_lat.dout : 8'd0);
            chk("bad_hdr_cnt", bad, m_bad);
        end
        // Inputs seen now are what the next rising edge samples.
        if (rst) begin
            m_state = 0; m_lat = '0; m_d1 = 1'b0; m_d2 = 1'b0; m_idle = 0; m_bad = 0;
        end else begin
            now_s = m_d2;
            m_d2  = m_d1;
            m_d1  = estop_in;
            valid = fbus.pkg_ok && (cur_f.hdr == DATA);
            if (fbus.pkg_ok && !valid && m_bad < 65535) m_bad++;
            if (now_s) begin
                m_state = 3;
            end else if (m_state == 3) begin
                if (valid && cur_f.en == 8'h00) m_state = 0;
            end else if (valid) begin
                m_state = 1;
                m_lat   = cur_f;
                m_idle  = 0;
            end else if (m_state == 1) begin
`ifdef FRAME_WATCHDOG_EN
                m_idle++;
                if (m_idle >= TC) m_state = 2;
`endif
            end
        end
        m_live = 1'b1;
    end

    initial begin
        frame_t fa, fx, fb, fc, fd, fg, fe, ff, fr1, fr0;
        fa  = mk(DATA, 32'h00002710, 32'hFFFFFFFB, 32'h00010000, 32'h7FFFFFFF, 32'h80000000,
                 8'hA0, 16'h1234, 16'hABCD, 8'h5A);
        fx  = mk(32'h78787878, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 8'hFF, 16'h1111, 16'h2222, 8'hFF);
        fb  = mk(DATA, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 8'hF8, 16'h0001, 16'h0002, 8'h01);
        fc  = mk(DATA, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'h12345678, 8'h08, 16'hFFFF, 16'h0000, 8'hC3);
        fd  = mk(DATA, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 8'h80, 16'h0A0A, 16'h0B0B, 8'h0D);
        fg  = mk(DATA, 32'hFFFFFF00, 32'd1, 32'd0, 32'd0, 32'd0, 8'h40, 16'h5555, 16'hAAAA, 8'h66);
        fe  = mk(DATA, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 8'hF8, 16'h1, 16'h2, 8'hEE);
        ff  = mk(DATA, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 8'hF8, 16'h9, 16'h9, 8'hF0);
        fr1 = mk(DATA, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h01, 16'h0, 16'h0, 8'h99);
        fr0 = mk(DATA, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 16'h0, 16'h0, 8'h77);

        rst          = 1'b1;
        estop_in     = 1'b0;
        cur_f        = '0;
        fbus.rx_data = '0;
        fbus.pkg_ok  = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge sysclk);
        chk("lit_reset_state", st, 2'd0);
        chk("lit_reset_hdr", htx, 32'h64617461);
        chk("lit_reset_error", err, 1'b0);
        align();

        send(fa);
        @(negedge sysclk);
        chk("lit_a_state", st, 2'd1);
        chk("lit_a_joint0", jfc[31:0], 32'h00002710);
        chk("lit_a_joint1", jfc[63:32], 32'hFFFFFFFB);
        chk("lit_a_enable", jen, 5'b00101);
        chk("lit_a_setpoint", sp, 32'hABCD1234);
        align();

        send(fx);
        @(negedge sysclk);
        chk("lit_bad_cnt", bad, 16'd1);
        chk("lit_bad_dout", dout, 8'h5A);
        align();

        send(fb);
        send(fc);
        @(negedge sysclk);
        chk("lit_c_joint4", jfc[159:128], 32'h12345678);
        chk("lit_c_enable", jen, 5'b10000);
        chk("lit_c_dout", dout, 8'hC3);
        align();

`ifdef FRAME_WATCHDOG_EN
        idle(49);
        send(fx);
        idle(48);
        @(negedge sysclk);
        chk("lit_wd_not_yet", st, 2'd1);
        align();
        @(negedge sysclk);
        chk("lit_wd_state", st, 2'd2);
        chk("lit_wd_error", err, 1'b1);
        chk("lit_wd_cmd", jfc, 160'd0);
        align();
        send(fd);
        @(negedge sysclk);
        chk("lit_wd_rerun", st, 2'd1);
        align();
        idle(98);
        send(fg);
        @(negedge sysclk);
        chk("lit_wd_race_state", st, 2'd1);
        chk("lit_wd_race_dout", dout, 8'h66);
        align();
`else
        idle(10*TC);
        @(negedge sysclk);
        chk("lit_nowd_state", st, 2'd1);
        chk("lit_nowd_error", err, 1'b0);
        chk("lit_nowd_dout", dout, 8'hC3);
        align();
`endif

        estop_in = 1'b1;
        send(fe);
        idle(1);
        send(ff);
        @(negedge sysclk);
        chk("lit_estop_state", st, 2'd3);
        chk("lit_estop_hdr", htx, 32'h65737470);
        chk("lit_estop_cmd", jfc, 160'd0);
        align();

        send(fr0);
        @(negedge sysclk);
        chk("lit_estop_held", st, 2'd3);
        align();

        estop_in = 1'b0;
        idle(3);
        send(fr1);
        @(negedge sysclk);
        chk("lit_rearm_refused", st, 2'd3);
        align();
        send(fx);
        send(fr0);
        @(negedge sysclk);
        chk("lit_rearm_state", st, 2'd0);
        chk("lit_rearm_dout", dout, 8'h00);
        chk("lit_rearm_hdr", htx, 32'h64617461);
        align();

        send(fa);
        @(negedge sysclk);
        chk("lit_rerun_state", st, 2'd1);
        align();

        rst = 1'b1;
        send(fb);
        rst = 1'b0;
        @(negedge sysclk);
        chk("lit_rst_state", st, 2'd0);
        chk("lit_rst_bad", bad, 16'd0);
        chk("lit_rst_cmd", jfc, 160'd0);
        align();
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
